// File: rtl/dram_sipo_rd_ctrl_if.sv
// Request/data bundle between the read-capture sequencer, the command scheduler,
// the SIPO and the read-return consumer.
interface dram_sipo_rd_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int BL_W  = 4,
   parameter int CL_W  = 3
);
   logic             rd_start;
   logic [BL_W-1:0]  burst_len;
   logic [CL_W-1:0]  cas_lat;
   logic [WIDTH-1:0] sipo_data;
   logic             shift_en;
   logic             busy;
   logic [WIDTH-1:0] word_data;
   logic             word_valid;
   logic             word_ready;
   logic             overflow;
   logic             clr_ovf;
   logic             done;

   modport master (
      input  rd_start, burst_len, cas_lat, sipo_data, word_ready, clr_ovf,
      output shift_en, busy, word_data, word_valid, overflow, done
   );

   modport slave (
      output rd_start, burst_len, cas_lat, sipo_data, word_ready, clr_ovf,
      input  shift_en, busy, word_data, word_valid, overflow, done
   );
endinterface

// File: rtl/dram_sipo_rd_ctrl.sv
// Read-capture sequencer: CAS wait, burst_len*WIDTH shift cycles, word capture 2 cycles
// after each word's last shift; a word arriving while the consumer stalls is dropped (overflow).
module dram_sipo_rd_ctrl #(
   parameter int WIDTH = 8,
   parameter int BL_W  = 4,
   parameter int CL_W  = 3
) (
   input logic                  clk,
   input logic                  rst_b,
   dram_sipo_rd_ctrl_if.master  bus
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LAT   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_nxt_state;
   logic [CL_W-1:0]  r_lat_cnt;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [BL_W-1:0]  r_word_cnt;
   logic [BL_W-1:0]  r_burst;
   logic             r_cap;
   logic             r_shift_en;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_word_data;
   logic             r_word_valid;
   logic             r_overflow;
   logic             w_bit_last;
   logic             w_word_last;
   logic             w_drop;

   assign w_bit_last  = (r_bit_cnt == BIT_W'(WIDTH - 1));
   assign w_word_last = (r_word_cnt == (r_burst - BL_W'(1)));
   assign w_drop      = r_cap && r_word_valid && !bus.word_ready;

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE:    if (bus.rd_start) w_nxt_state = (bus.cas_lat != '0) ? LAT : SHIFT;
         LAT:     if (r_lat_cnt == '0) w_nxt_state = SHIFT;
         SHIFT:   if (w_bit_last && w_word_last) w_nxt_state = DRAIN;
         default: w_nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state    <= IDLE;
         r_lat_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_burst    <= '0;
         r_cap      <= 1'b0;
         r_shift_en <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         // Outputs follow the next state so they line up with the state they describe.
         r_shift_en <= (w_nxt_state == SHIFT);
         r_busy     <= (w_nxt_state != IDLE);
         r_done     <= (r_state == DRAIN);
         r_cap      <= (r_state == SHIFT) && w_bit_last;
         case (r_state)
            IDLE: begin
               if (bus.rd_start) begin
                  r_burst    <= (bus.burst_len == '0) ? BL_W'(1) : bus.burst_len;
                  r_lat_cnt  <= bus.cas_lat - CL_W'(1);
                  r_bit_cnt  <= '0;
                  r_word_cnt <= '0;
               end
            end
            LAT: begin
               if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - CL_W'(1);
            end
            SHIFT: begin
               r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BIT_W'(1);
               if (w_bit_last) r_word_cnt <= r_word_cnt + BL_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Capture samples sipo_data in the cycle after a word's last shift, before the next shift lands.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_word_data  <= '0;
         r_word_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (r_cap && (!r_word_valid || bus.word_ready)) begin
            r_word_data  <= bus.sipo_data;
            r_word_valid <= 1'b1;
         end else if (r_word_valid && bus.word_ready) begin
            r_word_valid <= 1'b0;
         end
         if (w_drop)           r_overflow <= 1'b1;
         else if (bus.clr_ovf) r_overflow <= 1'b0;
      end
   end

   assign bus.shift_en   = r_shift_en;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.word_data  = r_word_data;
   assign bus.word_valid = r_word_valid;
   assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_dram_sipo_rd_ctrl.sv
// Directed bench: SIPO model fed from a bit queue, negedge monitor, hand-computed cycle/data expectations.
module tb_dram_sipo_rd_ctrl;

   localparam int WIDTH = 8;
   localparam int BL_W  = 4;
   localparam int CL_W  = 3;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   cyc = 0;

   dram_sipo_rd_ctrl_if #(.WIDTH(WIDTH), .BL_W(BL_W), .CL_W(CL_W)) bus();

   dram_sipo_rd_ctrl #(.WIDTH(WIDTH), .BL_W(BL_W), .CL_W(CL_W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SIPO model: MSB-first serial input
   logic       dq = 1'b0;
   logic [7:0] sipo = 8'h00;
   logic       bitq[$];
   always @(posedge clk) if (bus.shift_en) sipo <= {sipo[6:0], dq};
   assign bus.sipo_data = sipo;

   int         sh_cnt, sh_first, sh_last, sh_gaps, busy_last, done_cnt, done_first;
   logic       prev_vld;
   logic [7:0] wq_dat[$];
   int         wq_cyc[$];
   int         n_chk = 0;
   int         n_err = 0;

   always @(negedge clk) begin
      if (bus.shift_en) begin
         if (sh_cnt > 0 && cyc != sh_last + 1) sh_gaps++;
         if (sh_cnt == 0) sh_first = cyc;
         sh_last = cyc;
         sh_cnt++;
         dq = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      end
      if (bus.word_valid && !prev_vld) begin
         wq_dat.push_back(bus.word_data);
         wq_cyc.push_back(cyc);
      end
      prev_vld = bus.word_valid;
      if (bus.busy) busy_last = cyc;
      if (bus.done) begin
         if (done_cnt == 0) done_first = cyc;
         done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_mon();
      sh_cnt = 0; sh_first = -1; sh_last = -1; sh_gaps = 0;
      busy_last = -1; done_cnt = 0; done_first = -1;
      wq_dat.delete(); wq_cyc.delete(); bitq.delete();
   endtask

   task automatic load_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);
   endtask

   function automatic logic [7:0] wd(input int i);
      return (wq_dat.size() > i) ? wq_dat[i] : 8'hxx;
   endfunction

   function automatic int wc(input int i);
      return (wq_cyc.size() > i) ? wq_cyc[i] : -1;
   endfunction

   task automatic issue(input int bl, input int cl, output int c);
      @(negedge clk);
      c = cyc;
      bus.rd_start  = 1'b1;
      bus.burst_len = BL_W'(bl);
      bus.cas_lat   = CL_W'(cl);
      @(negedge clk);
      bus.rd_start = 1'b0;
   endtask

   int c;

   initial begin
      bus.rd_start = 1'b0; bus.burst_len = '0; bus.cas_lat = '0;
      bus.word_ready = 1'b1; bus.clr_ovf = 1'b0;
      clear_mon();
      prev_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_shift_en", bus.shift_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.word_valid, 0);
      chk("rst_data", bus.word_data, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_done", bus.done, 0);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // cas_lat=2, burst_len=1, A5
      clear_mon(); load_word(8'hA5);
      issue(1, 2, c);
      repeat (16) @(negedge clk);
      chk("A_sh_first", sh_first, c + 3);
      chk("A_sh_last", sh_last, c + 10);
      chk("A_sh_cnt", sh_cnt, 8);
      chk("A_gaps", sh_gaps, 0);
      chk("A_nwords", wq_dat.size(), 1);
      chk("A_data", wd(0), 8'hA5);
      chk("A_vld_cyc", wc(0), c + 12);
      chk("A_done_cyc", done_first, c + 12);
      chk("A_busy_last", busy_last, c + 11);

      // cas_lat=0, burst_len=3
      clear_mon(); load_word(8'h11); load_word(8'h22); load_word(8'h33);
      issue(3, 0, c);
      repeat (30) @(negedge clk);
      chk("B_sh_first", sh_first, c + 1);
      chk("B_sh_cnt", sh_cnt, 24);
      chk("B_gaps", sh_gaps, 0);
      chk("B_nwords", wq_dat.size(), 3);
      chk("B_w0", wd(0), 8'h11);
      chk("B_w1", wd(1), 8'h22);
      chk("B_w2", wd(2), 8'h33);
      chk("B_c0", wc(0), c + 10);
      chk("B_c1", wc(1), c + 18);
      chk("B_c2", wc(2), c + 26);
      chk("B_done_cyc", done_first, c + 26);
      chk("B_ovf", bus.overflow, 0);

      // rd_start during SHIFT and DRAIN ignored, on the done cycle accepted
      clear_mon(); load_word(8'h3C); load_word(8'hC3);
      bus.burst_len = BL_W'(1); bus.cas_lat = '0;
      @(negedge clk);
      c = cyc;
      for (int k = 0; k < 26; k++) begin
         bus.rd_start = (k == 0 || k == 4 || k == 9 || k == 10);
         @(negedge clk);
      end
      bus.rd_start = 1'b0;
      chk("F_sh_cnt", sh_cnt, 16);
      chk("F_gaps", sh_gaps, 1);
      chk("F_sh_last", sh_last, c + 18);
      chk("F_done_cnt", done_cnt, 2);
      chk("F_done_first", done_first, c + 10);
      chk("F_w0", wd(0), 8'h3C);
      chk("F_w1", wd(1), 8'hC3);
      chk("F_c1", wc(1), c + 20);

      // burst_len=2, consumer stalled: second word dropped
      clear_mon(); load_word(8'h11); load_word(8'h22);
      bus.word_ready = 1'b0;
      issue(2, 0, c);
      repeat (22) @(negedge clk);
      chk("C_nwords", wq_dat.size(), 1);
      chk("C_valid", bus.word_valid, 1);
      chk("C_data", bus.word_data, 8'h11);
      chk("C_ovf", bus.overflow, 1);
      chk("C_done_cnt", done_cnt, 1);
      bus.word_ready = 1'b1;
      @(negedge clk);
      bus.word_ready = 1'b0;
      chk("C_valid_clr", bus.word_valid, 0);
      chk("C_ovf_sticky", bus.overflow, 1);
      chk("C_data_hold", bus.word_data, 8'h11);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      chk("C_ovf_clr", bus.overflow, 0);
      bus.word_ready = 1'b1;
      @(negedge clk);

      // burst_len=0 behaves as 1
      clear_mon(); load_word(8'h5A);
      issue(0, 1, c);
      repeat (16) @(negedge clk);
      chk("D_sh_first", sh_first, c + 2);
      chk("D_sh_cnt", sh_cnt, 8);
      chk("D_nwords", wq_dat.size(), 1);
      chk("D_data", wd(0), 8'h5A);
      chk("D_done_cnt", done_cnt, 1);

      // reset at burst_len=3, word 2, bit 4
      clear_mon(); load_word(8'h11); load_word(8'h22); load_word(8'h33);
      issue(3, 0, c);
      repeat (12) @(negedge clk);
      chk("R_pre_shift", bus.shift_en, 1);
      chk("R_pre_data", bus.word_data, 8'h11);
      rst_b = 1'b0;
      #1;
      chk("R_shift_en", bus.shift_en, 0);
      chk("R_busy", bus.busy, 0);
      chk("R_valid", bus.word_valid, 0);
      chk("R_data", bus.word_data, 0);
      chk("R_ovf", bus.overflow, 0);
      chk("R_done", bus.done, 0);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      clear_mon(); load_word(8'h96);
      issue(1, 0, c);
      repeat (14) @(negedge clk);
      chk("R2_sh_cnt", sh_cnt, 8);
      chk("R2_data", wd(0), 8'h96);
      chk("R2_vld_cyc", wc(0), c + 10);
      chk("R2_done_cnt", done_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dram_sipo_rd_ctrl.md
Name: dram_sipo_rd_ctrl

Overview:
Read-capture sequencer for the DRAM data-pin SIPO deserializer. On a read request it waits the programmed CAS latency, then drives the SIPO shift enable for burst_len*WIDTH consecutive cycles. It captures each completed parallel word from the SIPO and presents it to the read-data consumer on a valid/ready handshake. It sits between the command scheduler (request side) and the read-return path (data side).

Parameters:
WIDTH, 8, bits per word; must match the SIPO width
BL_W, 4, width of burst_len; the maximum burst is 2^BL_W-1 words
CL_W, 3, width of cas_lat

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
rd_start  input  1  one-cycle read request, sampled only in IDLE
burst_len  input  BL_W  words per burst, sampled with rd_start; 0 is treated as 1
cas_lat  input  CL_W  cycles between the accept edge and the first shift cycle, sampled with rd_start
sipo_data  input  WIDTH  parallel output of the SIPO
shift_en  output  1  drives the SIPO load/shift enable
busy  output  1  high in every state except IDLE
word_data  output  WIDTH  captured word
word_valid  output  1  word_data is valid
word_ready  input  1  consumer accepts the word
overflow  output  1  sticky flag: a word was dropped
clr_ovf  input  1  synchronous clear of overflow
done  output  1  one-cycle pulse at the end of a burst

Behaviour:
- Reset (async, rst_b low): state=IDLE; shift_en=0, busy=0, word_valid=0, word_data=0, overflow=0, done=0; all counters 0.
- All outputs are registered. Reset asserted mid-burst aborts the burst immediately and drops any pending word.
- States: IDLE, LAT, SHIFT, DRAIN.
- IDLE: when rd_start=1 at an edge, latch burst_len (0 becomes 1) and cas_lat. Go to LAT if cas_lat>0, otherwise go directly to SHIFT.
- LAT: a latency counter loads cas_lat-1 on entry and decrements each cycle. At 0, go to SHIFT. Total time in LAT is exactly cas_lat cycles.
- SHIFT: shift_en=1 every cycle.
  - bit_cnt counts 0..WIDTH-1 and wraps.
  - word_cnt increments on each wrap.
  - After the shift cycle with bit_cnt=WIDTH-1 of the last word, go to DRAIN.
  - Total shift_en high time is exactly burst_len*WIDTH consecutive cycles with no gaps.
- Capture rule: a word is complete in sipo_data during the cycle after its last shift cycle. The controller registers sipo_data at the end of that cycle.
  - For words 1..n-1, that cycle is the first shift cycle of the next word. Because the register samples the pre-edge SIPO value, this is correct.
  - For the last word, that cycle is DRAIN.
  - Therefore word_valid rises 2 cycles after the word's final shift cycle.
- DRAIN: shift_en=0, perform the final capture, done=1 for the following cycle, then return to IDLE. busy stays high through DRAIN.
- Handshake:
  - word_valid stays high until a cycle with word_ready=1; it clears at that edge.
  - Capture with word_valid=0, or word_valid=1 and word_ready=1 in the same cycle: load the new word, word_valid=1.
  - Capture with word_valid=1 and word_ready=0: keep the old word, drop the new one, set overflow.
- overflow: clr_ovf clears it. If a set and clr_ovf coincide, set wins.
- rd_start while busy=1 is ignored; no queuing.
- word_data holds its last value when word_valid=0.
- word_valid and done may overlap; word_ready may be held high permanently.

Test Plan:
- Reset mid-SHIFT (rst_b low at burst_len=3, word 2, bit 4) -> all outputs 0 asynchronously; the next rd_start is serviced normally.
- rd_start at edge T0, cas_lat=2, burst_len=1, dq serial 1,0,1,0,0,1,0,1 with word_ready=1:
  - shift_en high cycles T0+3..T0+10;
  - word_valid with word_data=8'hA5 in cycle T0+12;
  - done in cycle T0+12; busy low from T0+12.
- cas_lat=0, burst_len=3, words 8'h11, 8'h22, 8'h33, word_ready=1 -> shift_en high 24 contiguous cycles; three word_valid pulses spaced 8 cycles apart carrying 11, 22, 33; overflow=0.
- burst_len=2, word_ready=0 throughout -> word_data=8'h11 held, 8'h22 dropped, overflow=1. Then word_ready=1 for one cycle -> word_valid clears. Then clr_ovf -> overflow=0.
- burst_len=0 -> behaves as 1: 8 shift cycles and a single word.
- rd_start pulsed again during SHIFT and during DRAIN -> ignored. rd_start on the first IDLE cycle after DRAIN (same cycle as done) -> accepted.
